// File: rtl/dcache_arb_pkg.sv
// Shared types and default widths for the Dcache port arbiter.
package dcache_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned SEL_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: with both requesting, the one not served last wins.
module rr_arb2
  import dcache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output owner_t     grant,
  output logic       any
);

  always_comb begin
    any = |req;
    if (&req) grant = ~last;
    else      grant = req[1];
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin sequencer of two masters onto the single Dcache data port.
// Optional per-transaction abort timer enabled by defining DCARB_TIMEOUT_EN.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              dc_re,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_raddr,
  output logic [ADDR_W-1:0] dc_waddr,
  output logic [DATA_W-1:0] dc_wdata,
  output logic [SEL_W-1:0]  dc_sel,
  input  logic              dc_stall,
  input  logic              dc_rvalid,
  input  logic [DATA_W-1:0] dc_rdata
);

  arb_state_t        state;
  owner_t            owner, last, pick;
  logic              pick_any;
  logic              abort;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [SEL_W-1:0]  win_sel;

  rr_arb2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    win_we    = pick ? m1_we    : m0_we;
    win_addr  = pick ? m1_addr  : m0_addr;
    win_wdata = pick ? m1_wdata : m0_wdata;
    win_sel   = pick ? m1_sel   : m0_sel;
  end

`ifdef DCARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt;

  // Held at zero in IDLE, so it restarts from zero on every entry to REQ.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // Abort on the edge where the count would reach TIMEOUT-1.
  assign abort = (state != IDLE) && (cnt == CNT_W'(TIMEOUT - 2));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      m0_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_gnt    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
      dc_re     <= 1'b0;
      dc_we     <= 1'b0;
      dc_raddr  <= '0;
      dc_waddr  <= '0;
      dc_wdata  <= '0;
      dc_sel    <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            owner  <= pick;
            state  <= REQ;
            dc_sel <= win_sel;
            if (win_we) begin
              dc_we    <= 1'b1;
              dc_waddr <= win_addr;
              dc_wdata <= win_wdata;
            end else begin
              dc_re    <= 1'b1;
              dc_raddr <= win_addr;
            end
          end
        end
        REQ: begin
          if (!dc_stall || abort) begin
            dc_re    <= 1'b0;
            dc_we    <= 1'b0;
            dc_raddr <= '0;
            dc_waddr <= '0;
            dc_wdata <= '0;
            dc_sel   <= '0;
            last     <= owner;
            if (owner) begin
              m1_gnt <= 1'b1;
              m1_err <= abort;
            end else begin
              m0_gnt <= 1'b1;
              m0_err <= abort;
            end
            state <= (dc_we || abort) ? IDLE : RESP;
          end
        end
        RESP: begin
          if (dc_rvalid || abort) begin
            last  <= owner;
            state <= IDLE;
            if (owner) begin
              m1_rvalid <= 1'b1;
              m1_rdata  <= abort ? '0 : dc_rdata;
              m1_err    <= abort;
            end else begin
              m0_rvalid <= 1'b1;
              m0_rdata  <= abort ? '0 : dc_rdata;
              m0_err    <= abort;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter; honours DCARB_TIMEOUT_EN for the timeout case.
module tb_dcache_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          req_v   [2];
  logic          we_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic [3:0]    sel_v   [2];

  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          dc_re, dc_we;
  logic [AW-1:0] dc_raddr, dc_waddr;
  logic [DW-1:0] dc_wdata;
  logic [3:0]    dc_sel;
  logic          dc_stall, dc_rvalid;
  logic [DW-1:0] dc_rdata;

  dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]), .m0_sel(sel_v[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]), .m1_sel(sel_v[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dc_re(dc_re), .dc_we(dc_we), .dc_raddr(dc_raddr), .dc_waddr(dc_waddr),
    .dc_wdata(dc_wdata), .dc_sel(dc_sel),
    .dc_stall(dc_stall), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endfunction

  typedef struct { int owner; logic err; } gexp_t;
  typedef struct { logic [DW-1:0] data; logic err; } rexp_t;
  gexp_t gq[$];
  rexp_t rq0[$];
  rexp_t rq1[$];

  // Cache model controls and backing store.
  logic          stall_forever = 1'b0;
  int            stall_cfg     = 0;
  int            stall_left    = 0;
  int            rv_delay      = 1;
  logic          rv_pend       = 1'b0;
  int            rv_cnt        = 0;
  logic [7:0]    rv_addr       = '0;
  logic [DW-1:0] mem [256];
  int            re_cycles     = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    dc_stall  = 1'b0;
    dc_rvalid = 1'b0;
    dc_rdata  = '0;
    forever begin
      @(negedge clk);
      dc_rvalid = 1'b0;
      if (rv_pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          dc_rvalid = 1'b1;
          dc_rdata  = mem[rv_addr];
          rv_pend   = 1'b0;
        end
      end
      dc_stall = 1'b0;
      if (dc_re || dc_we) begin
        if (stall_forever || stall_left > 0) begin
          dc_stall = 1'b1;
          if (stall_left > 0) stall_left--;
        end else begin
          stall_left = stall_cfg;
          if (dc_we) begin
            for (int b = 0; b < 4; b++)
              if (dc_sel[b]) mem[dc_waddr[7:0]][8*b +: 8] = dc_wdata[8*b +: 8];
          end else begin
            rv_pend = 1'b1;
            rv_cnt  = rv_delay;
            rv_addr = dc_raddr[7:0];
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a gnt or rvalid.
  initial begin
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (dc_re) re_cycles++;
      if (m0_gnt || m1_gnt) begin
        chk("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'd0);
        if (gq.size() == 0) fail_now("gnt_unexpected", $sformatf("m0_gnt=%0b m1_gnt=%0b with nothing expected", m0_gnt, m1_gnt));
        else begin
          g = gq.pop_front();
          chk("gnt_owner", 64'(m1_gnt), 64'(g.owner));
          chk("gnt_err", 64'(m1_gnt ? m1_err : m0_err), 64'(g.err));
        end
      end
      if (m0_rvalid) begin
        if (rq0.size() == 0) fail_now("m0_rvalid_unexpected", $sformatf("rdata 0x%0h", m0_rdata));
        else begin
          r = rq0.pop_front();
          chk("m0_rdata", 64'(m0_rdata), 64'(r.data));
          chk("m0_rvalid_err", 64'(m0_err), 64'(r.err));
        end
      end
      if (m1_rvalid) begin
        if (rq1.size() == 0) fail_now("m1_rvalid_unexpected", $sformatf("rdata 0x%0h", m1_rdata));
        else begin
          r = rq1.pop_front();
          chk("m1_rdata", 64'(m1_rdata), 64'(r.data));
          chk("m1_rvalid_err", 64'(m1_err), 64'(r.err));
        end
      end
      if ((m0_err && !m0_gnt && !m0_rvalid) || (m1_err && !m1_gnt && !m1_rvalid))
        fail_now("err_alone", "err asserted without gnt or rvalid");
    end
  end

  task automatic master_op(input int m, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    req_v[m] = 1'b1; we_v[m] = w; addr_v[m] = a; wdata_v[m] = d; sel_v[m] = s;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      seen = (m == 1) ? m1_gnt : m0_gnt;
    end
    req_v[m] = 1'b0;
    if (!seen) fail_now("gnt_wait", $sformatf("m%0d no gnt within 200 cycles", m));
  endtask

  task automatic wait_rv(input int m);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (m == 1) ? m1_rvalid : m0_rvalid;
    end
    if (!seen) fail_now("rvalid_wait", $sformatf("m%0d no rvalid within 50 cycles", m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, cyc_b;
    logic err_seen;
    logic [DW-1:0] w;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; we_v[m] = 1'b0; addr_v[m] = '0; wdata_v[m] = '0; sel_v[m] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", 64'(|{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                              dc_re, dc_we, dc_raddr, dc_waddr, dc_wdata, dc_sel}), 64'd0);

    // 1: single zero-stall write, cycle-exact
    gq.push_back('{owner: 0, err: 1'b0});
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd3; wdata_v[0] = 32'h1234; sel_v[0] = 4'hF;
    @(posedge clk); #1;
    chk("t1_dc_we", 64'(dc_we), 64'd1);
    chk("t1_dc_waddr", 64'(dc_waddr), 64'd3);
    chk("t1_dc_wdata", 64'(dc_wdata), 64'h1234);
    chk("t1_dc_sel", 64'(dc_sel), 64'hF);
    chk("t1_dc_re", 64'(dc_re), 64'd0);
    chk("t1_gnt_early", 64'(m0_gnt), 64'd0);
    @(posedge clk); #1;
    chk("t1_gnt", 64'(m0_gnt), 64'd1);
    chk("t1_dc_we_drop", 64'(dc_we), 64'd0);
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    chk("t1_gnt_pulse", 64'(m0_gnt), 64'd0);
    repeat (2) @(posedge clk); #1;

    // 2: both masters contending from reset priority
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    gq.push_back('{owner: 0, err: 1'b0});
    gq.push_back('{owner: 1, err: 1'b0});
    gq.push_back('{owner: 0, err: 1'b0});
    gq.push_back('{owner: 1, err: 1'b0});
    fork
      begin
        master_op(0, 1'b1, 32'h10, 32'hA0A0, 4'hF, cyc);
        master_op(0, 1'b1, 32'h11, 32'hA1A1, 4'hF, cyc);
      end
      begin
        master_op(1, 1'b1, 32'h20, 32'hB0B0, 4'hF, cyc_b);
        master_op(1, 1'b1, 32'h21, 32'hB1B1, 4'hF, cyc_b);
      end
    join
    repeat (2) @(posedge clk); #1;
    gq.push_back('{owner: 1, err: 1'b0});
    master_op(1, 1'b1, 32'h30, 32'hC0C0, 4'hF, cyc);
    chk("t2_m1_alone_latency", 64'(cyc), 64'd2);

    // 3: stalled read from m1
    mem[7] = 32'hBEEF;
    stall_left = 3; stall_cfg = 0; rv_delay = 2;
    re_cycles = 0;
    gq.push_back('{owner: 1, err: 1'b0});
    rq1.push_back('{data: 32'hBEEF, err: 1'b0});
    master_op(1, 1'b0, 32'd7, 32'd0, 4'hF, cyc);
    chk("t3_gnt_latency", 64'(cyc), 64'd5);
    chk("t3_dc_re_cycles", 64'(re_cycles), 64'd4);
    wait_rv(1);
    rv_delay = 1;
    repeat (2) @(posedge clk); #1;

    // 4: reset while waiting for read data; the late dc_rvalid must be ignored
    rv_delay = 6;
    gq.push_back('{owner: 0, err: 1'b0});
    master_op(0, 1'b0, 32'd5, 32'd0, 4'hF, cyc);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("t4_outputs_zero", 64'(|{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                                   dc_re, dc_we, dc_raddr, dc_waddr, dc_wdata, dc_sel}), 64'd0);
    end
    rv_delay = 1;
    gq.push_back('{owner: 0, err: 1'b0});
    gq.push_back('{owner: 1, err: 1'b0});
    fork
      master_op(0, 1'b1, 32'h40, 32'h4040, 4'hF, cyc);
      master_op(1, 1'b1, 32'h41, 32'h4141, 4'hF, cyc_b);
    join
    chk("t4_m0_first", 64'(cyc), 64'd2);
    repeat (2) @(posedge clk); #1;

    // 5: cache stall stuck high
    stall_forever = 1'b1;
`ifdef DCARB_TIMEOUT_EN
    gq.push_back('{owner: 0, err: 1'b1});
    master_op(0, 1'b1, 32'd9, 32'h9999, 4'hF, cyc);
    chk("t5_abort_cycle", 64'(cyc), 64'(TMO));
    stall_forever = 1'b0;
`else
    err_seen = 1'b0;
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd9; wdata_v[0] = 32'h9999; sel_v[0] = 4'hF;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      err_seen = err_seen | m0_err;
    end
    chk("t5_dc_we_held", 64'(dc_we), 64'd1);
    chk("t5_no_err", 64'(err_seen), 64'd0);
    req_v[0] = 1'b0;
    stall_forever = 1'b0;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;

    // 6: write then read back 16 words through different masters
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      gq.push_back('{owner: 0, err: 1'b0});
      master_op(0, 1'b1, AW'(i), w, 4'hF, cyc);
      gq.push_back('{owner: 1, err: 1'b0});
      rq1.push_back('{data: w, err: 1'b0});
      master_op(1, 1'b0, AW'(i), 32'd0, 4'hF, cyc);
      wait_rv(1);
    end

    repeat (4) @(posedge clk); #1;
    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("m0_rd_queue_drained", 64'(rq0.size()), 64'd0);
    chk("m1_rd_queue_drained", 64'(rq1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
